conv_mac_engine: RTL and testbench

Parametrised multi-channel convolution multiply-accumulate engine, the next generation of the convolution datapath behind the AXI control block. It accepts a run of up to `MAX_TAPS` kernel taps, each carrying `CHANNELS` operand pairs, and accumulates all products at full precision. It then reduces the per-channel accumulators to one result and holds it under a valid/ready handshake. It replaces the fixed three-multiplier `direct` arrangement with a configurable channel count, a per-run tap count, input/output flow control and an error flag.

---
 rtl/conv_mac_engine.sv | 196 +++++++++++++++++++
 tb/tb_conv_mac_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: multi-channel convolution multiply-accumulate engine.
// Accepts a run of 1..MAX_TAPS taps, each carrying CHANNELS operand pairs,
// accumulates every product at full precision in one lane per channel, then
// reduces the lanes to one result held under a valid/ready handshake.
// Build option: define CONV_SATURATE_EN to clamp finalSum to the signed
// BIT_LENGTH range instead of truncating finalAccumulate.

// Per-channel accumulator lane: acc += sext(a) * sext(b) when enabled.
module conv_mac_lane #(
   parameter int BIT_LENGTH = 8,
   parameter int ACC_WIDTH  = 21
) (
   input  logic                        Clk,
   input  logic                        Rst,
   input  logic                        clr,
   input  logic                        en,
   input  logic [BIT_LENGTH-1:0]       a,
   input  logic [BIT_LENGTH-1:0]       b,
   output logic signed [ACC_WIDTH-1:0] acc
);
   logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
   logic signed [ACC_WIDTH-1:0] a_ext, b_ext, prod;

   // Sign-extend operands to the accumulator width so the product cannot wrap.
   always_comb begin
      a_ext = $signed({{(ACC_WIDTH-BIT_LENGTH){a[BIT_LENGTH-1]}}, a});
      b_ext = $signed({{(ACC_WIDTH-BIT_LENGTH){b[BIT_LENGTH-1]}}, b});
      prod  = a_ext * b_ext;
   end

   // Clear has priority over accumulate.
   always_comb begin
      acc_d = acc_q;
      if (clr)     acc_d = '0;
      else if (en) acc_d = acc_q + prod;
   end

   // Accumulator register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) acc_q <= '0;
      else      acc_q <= acc_d;
   end

   assign acc = acc_q;
endmodule

module conv_mac_engine #(
   parameter int BIT_LENGTH = 8,
   parameter int CHANNELS   = 3,
   parameter int MAX_TAPS   = 9,
   parameter int ACC_WIDTH  = 2*BIT_LENGTH + $clog2(CHANNELS*MAX_TAPS),
   parameter int TAP_W      = $clog2(MAX_TAPS+1)
) (
   input  logic                           Clk,
   input  logic                           Rst,
   input  logic                           start,
   input  logic [TAP_W-1:0]               taps,
   input  logic                           clear,
   output logic                           busy,
   output logic                           error,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [CHANNELS*BIT_LENGTH-1:0] multiplier_input,
   input  logic [CHANNELS*BIT_LENGTH-1:0] multiplicand_input,
   output logic [TAP_W-1:0]               tap_count,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic signed [ACC_WIDTH-1:0]    finalAccumulate,
   output logic signed [BIT_LENGTH-1:0]   finalSum
);
   typedef enum logic [1:0] {S_IDLE, S_MAC, S_REDUCE, S_DONE} state_t;

   localparam logic [TAP_W-1:0] MAX_TAPS_W = TAP_W'(MAX_TAPS);

   state_t                        state_d, state_q;
   logic [TAP_W-1:0]              taps_d, taps_q;
   logic [TAP_W-1:0]              tap_count_d, tap_count_q;
   logic                          error_d, error_q;
   logic signed [ACC_WIDTH-1:0]   final_acc_d, final_acc_q;
   logic signed [BIT_LENGTH-1:0]  final_sum_d, final_sum_q;

   logic                          lane_clr, lane_en;
   logic [CHANNELS-1:0][ACC_WIDTH-1:0] acc_all;
   logic signed [ACC_WIDTH-1:0]   red_sum;
   logic signed [BIT_LENGTH-1:0]  narrow;
   logic                          taps_legal;

   // One accumulator lane per channel; all lanes share clear/enable.
   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      conv_mac_lane #(
         .BIT_LENGTH (BIT_LENGTH),
         .ACC_WIDTH  (ACC_WIDTH)
      ) u_lane (
         .Clk (Clk),
         .Rst (Rst),
         .clr (lane_clr),
         .en  (lane_en),
         .a   (multiplier_input[g*BIT_LENGTH +: BIT_LENGTH]),
         .b   (multiplicand_input[g*BIT_LENGTH +: BIT_LENGTH]),
         .acc (acc_all[g])
      );
   end

   // Reduce the channel accumulators and narrow the sum to BIT_LENGTH.
   always_comb begin
      red_sum = '0;
      for (int c = 0; c < CHANNELS; c++) red_sum = red_sum + $signed(acc_all[c]);
`ifdef CONV_SATURATE_EN
      if (red_sum > $signed({{(ACC_WIDTH-BIT_LENGTH+1){1'b0}}, {(BIT_LENGTH-1){1'b1}}}))
         narrow = $signed({1'b0, {(BIT_LENGTH-1){1'b1}}});
      else if (red_sum < $signed({{(ACC_WIDTH-BIT_LENGTH+1){1'b1}}, {(BIT_LENGTH-1){1'b0}}}))
         narrow = $signed({1'b1, {(BIT_LENGTH-1){1'b0}}});
      else
         narrow = red_sum[BIT_LENGTH-1:0];
`else
      narrow = red_sum[BIT_LENGTH-1:0];
`endif
   end

   assign taps_legal = (taps != '0) && (taps <= MAX_TAPS_W);

   // Control FSM next-state and datapath controls; clear overrides everything.
   always_comb begin
      state_d     = state_q;
      taps_d      = taps_q;
      tap_count_d = tap_count_q;
      error_d     = 1'b0;
      final_acc_d = final_acc_q;
      final_sum_d = final_sum_q;
      lane_clr    = 1'b0;
      lane_en     = 1'b0;
      if (clear) begin
         state_d     = S_IDLE;
         tap_count_d = '0;
         lane_clr    = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (taps_legal) begin
                     taps_d      = taps;
                     tap_count_d = '0;
                     lane_clr    = 1'b1;
                     state_d     = S_MAC;
                  end else begin
                     error_d = 1'b1;
                  end
               end
            end
            S_MAC: begin
               if (in_valid) begin
                  lane_en     = 1'b1;
                  tap_count_d = tap_count_q + TAP_W'(1);
                  if (tap_count_q + TAP_W'(1) == taps_q) state_d = S_REDUCE;
               end
            end
            S_REDUCE: begin
               final_acc_d = red_sum;
               final_sum_d = narrow;
               state_d     = S_DONE;
            end
            S_DONE: begin
               if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Control and result registers.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q     <= S_IDLE;
         taps_q      <= '0;
         tap_count_q <= '0;
         error_q     <= 1'b0;
         final_acc_q <= '0;
         final_sum_q <= '0;
      end else begin
         state_q     <= state_d;
         taps_q      <= taps_d;
         tap_count_q <= tap_count_d;
         error_q     <= error_d;
         final_acc_q <= final_acc_d;
         final_sum_q <= final_sum_d;
      end
   end

   assign busy            = (state_q != S_IDLE);
   assign in_ready        = (state_q == S_MAC);
   assign out_valid       = (state_q == S_DONE);
   assign error           = error_q;
   assign tap_count       = tap_count_q;
   assign finalAccumulate = final_acc_q;
   assign finalSum        = final_sum_q;
endmodule

// File: tb/tb_conv_mac_engine.sv
// Bench for conv_mac_engine: a transaction-level model (sums of products over
// the accepted taps) checked every cycle, plus directed runs with literal
// expectations. Honours CONV_SATURATE_EN for the narrowed result.
module tb_conv_mac_engine;
   localparam int BL   = 8;
   localparam int CH   = 3;
   localparam int MT   = 9;
   localparam int ACCW = 21;
   localparam int TW   = 4;

   logic Clk = 1'b0, Rst = 1'b0;
   logic start = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [TW-1:0] taps = '0;
   logic [CH*BL-1:0] mult_in = '0, mcand_in = '0;
   logic busy, error, in_ready, out_valid;
   logic [TW-1:0] tap_count;
   logic signed [ACCW-1:0] facc;
   logic signed [BL-1:0] fsum;

   int checks = 0;
   int errors = 0;

   conv_mac_engine dut (
      .Clk(Clk), .Rst(Rst), .start(start), .taps(taps), .clear(clear),
      .busy(busy), .error(error), .in_valid(in_valid), .in_ready(in_ready),
      .multiplier_input(mult_in), .multiplicand_input(mcand_in),
      .tap_count(tap_count), .out_valid(out_valid), .out_ready(out_ready),
      .finalAccumulate(facc), .finalSum(fsum)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic longint exp_sum(input longint v);
`ifdef CONV_SATURATE_EN
      if (v > 127)  return 127;
      if (v < -128) return -128;
      return v;
`else
      logic [BL-1:0] b;
      b = v[BL-1:0];
      return longint'($signed(b));
`endif
   endfunction

   function automatic logic [CH*BL-1:0] p3(input int a, input int b, input int c);
      return {BL'(c), BL'(b), BL'(a)};
   endfunction

   // Model: result of a run is the sum of all products over its accepted taps.
   longint m_acc = 0, m_res = 0;
   int     m_cnt = 0, m_taps = 0;
   logic   m_err = 1'b0;

   always @(negedge Clk) begin
      if (!Rst) begin
         m_acc = 0; m_res = 0; m_cnt = 0; m_taps = 0; m_err = 1'b0;
      end else begin
         chk("tap_count", longint'(tap_count), m_cnt);
         chk("error", longint'(error), longint'(m_err));
         if (error) chk("error_with_busy", longint'(busy), 0);
         if (in_ready) chk("ready_implies_busy", longint'(busy), 1);
         if (out_valid) begin
            chk("finalAccumulate", longint'(facc), m_res);
            chk("finalSum", longint'(fsum), exp_sum(m_res));
         end
         m_err = 1'b0;
         if (clear) begin
            m_acc = 0; m_cnt = 0;
         end else begin
            if (start && !busy) begin
               if (int'(taps) >= 1 && int'(taps) <= MT) begin
                  m_acc = 0; m_cnt = 0; m_taps = int'(taps);
               end else m_err = 1'b1;
            end
            if (in_valid && in_ready) begin
               for (int c = 0; c < CH; c++)
                  m_acc = m_acc + longint'($signed(mult_in[c*BL +: BL])) *
                                  longint'($signed(mcand_in[c*BL +: BL]));
               m_cnt++;
               if (m_cnt == m_taps) m_res = m_acc;
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clk); #1;
   endtask

   task automatic start_run(input int n);
      start = 1'b1; taps = TW'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic send_tap(input logic [CH*BL-1:0] m, input logic [CH*BL-1:0] k);
      bit hs;
      hs = 1'b0;
      mult_in = m; mcand_in = k; in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         if (in_ready) begin hs = 1'b1; break; end
      end
      @(posedge Clk); #1;
      in_valid = 1'b0;
      if (!hs) begin
         checks++; errors++;
         $display("FAIL send_tap_timeout in_ready stayed 0, required 1");
      end
   endtask

   task automatic wait_out();
      int cyc;
      cyc = 0;
      while (!out_valid && cyc < 50) begin tick(); cyc++; end
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL wait_out_timeout out_valid stayed 0, required 1");
      end
   endtask

   initial begin
      int lat;
      // Reset state
      @(negedge Clk);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_error", longint'(error), 0);
      chk("rst_in_ready", longint'(in_ready), 0);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_tap_count", longint'(tap_count), 0);
      chk("rst_facc", longint'(facc), 0);
      chk("rst_fsum", longint'(fsum), 0);
      tick();
      Rst = 1'b1;
      out_ready = 1'b1;
      tick();

      // 1: single tap, latency 3
      start = 1'b1; taps = TW'(1);
      mult_in = p3(1, 2, 3); mcand_in = p3(4, 5, 6); in_valid = 1'b1;
      tick();
      start = 1'b0;
      chk("s1_in_ready", longint'(in_ready), 1);
      chk("s1_busy", longint'(busy), 1);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 1) in_valid = 1'b0;
         if (out_valid) begin lat = k + 1; break; end
      end
      chk("s1_latency", lat, 3);
      chk("s1_facc", longint'(facc), 32);
      chk("s1_fsum", longint'(fsum), 32);
      tick();
      chk("s1_idle", longint'(busy), 0);

      // 2: full window positive extreme
      start_run(9);
      for (int t = 0; t < 9; t++) send_tap(p3(127, 127, 127), p3(127, 127, 127));
      wait_out();
      chk("s2_facc", longint'(facc), 435483);
`ifdef CONV_SATURATE_EN
      chk("s2_fsum", longint'(fsum), 127);
`else
      chk("s2_fsum", longint'(fsum), 27);
`endif
      tick();

      // 3: negative products
      start_run(2);
      for (int t = 0; t < 2; t++) send_tap(p3(-128, -128, -128), p3(127, 127, 127));
      wait_out();
      chk("s3_facc", longint'(facc), -97536);
`ifdef CONV_SATURATE_EN
      chk("s3_fsum", longint'(fsum), -128);
`else
      chk("s3_fsum", longint'(fsum), 0);
`endif
      tick();

      // 4: flow control, gaps, held result, ignored start, back-to-back
      out_ready = 1'b0;
      start_run(4);
      for (int t = 1; t <= 4; t++) begin
         send_tap(p3(t, t, t), p3(1, 2, 3));
         chk("s4_tap_count", longint'(tap_count), t);
         tick(); tick();
      end
      wait_out();
      chk("s4_facc", longint'(facc), 60);
      for (int h = 0; h < 5; h++) begin
         start = 1'b1; taps = TW'(1);
         tick();
         chk("s4_hold_valid", longint'(out_valid), 1);
         chk("s4_hold_facc", longint'(facc), 60);
      end
      start = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("s4_after_hs_busy", longint'(busy), 0);
      chk("s4_after_hs_valid", longint'(out_valid), 0);
      start_run(1);
      chk("s4_new_run_ready", longint'(in_ready), 1);
      send_tap(p3(2, 2, 2), p3(3, 3, 3));
      wait_out();
      chk("s4_new_facc", longint'(facc), 18);
      tick();

      // 5: illegal tap counts
      start = 1'b1; taps = TW'(0);
      tick();
      start = 1'b0;
      chk("s5_err0", longint'(error), 1);
      chk("s5_busy0", longint'(busy), 0);
      chk("s5_ready0", longint'(in_ready), 0);
      tick();
      chk("s5_err0_pulse", longint'(error), 0);
      start = 1'b1; taps = TW'(10);
      tick();
      start = 1'b0;
      chk("s5_err10", longint'(error), 1);
      chk("s5_busy10", longint'(busy), 0);
      chk("s5_ready10", longint'(in_ready), 0);
      tick();
      chk("s5_err10_pulse", longint'(error), 0);

      // 6: clear mid-run, async reset mid-run, then recovery
      start_run(9);
      for (int t = 0; t < 3; t++) send_tap(p3(1, 1, 1), p3(1, 1, 1));
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("s6_clr_busy", longint'(busy), 0);
      chk("s6_clr_ready", longint'(in_ready), 0);
      chk("s6_clr_cnt", longint'(tap_count), 0);
      chk("s6_clr_keep_facc", longint'(facc), 18);
      start_run(9);
      for (int t = 0; t < 2; t++) send_tap(p3(1, 1, 1), p3(1, 1, 1));
      #2 Rst = 1'b0;
      #1;
      chk("s6_rst_busy", longint'(busy), 0);
      chk("s6_rst_ready", longint'(in_ready), 0);
      chk("s6_rst_valid", longint'(out_valid), 0);
      chk("s6_rst_error", longint'(error), 0);
      chk("s6_rst_cnt", longint'(tap_count), 0);
      chk("s6_rst_facc", longint'(facc), 0);
      chk("s6_rst_fsum", longint'(fsum), 0);
      tick();
      Rst = 1'b1;
      tick();
      start_run(1);
      send_tap(p3(1, 2, 3), p3(4, 5, 6));
      wait_out();
      chk("s6_recover_facc", longint'(facc), 32);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
